// File: rtl/pbit_gibbs_scheduler.sv
// Gibbs-sweep controller for a time-multiplexed p-bit array: fetches each spin's
// local field, scales it by the annealing shift, and samples the new spin against an LFSR.
module pbit_gibbs_scheduler #(
  parameter int N_SPINS         = 8,
  parameter int IDX_W           = 3,
  parameter int SWEEPS_PER_STEP = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [15:0]        i_num_sweeps,
  output logic               o_field_req,
  output logic [IDX_W-1:0]   o_field_idx,
  input  logic               i_field_valid,
  input  logic [3:0]         i_field_val,
  output logic [N_SPINS-1:0] o_spins,
  output logic [1:0]         o_bit_shift,
  output logic               o_busy,
  output logic               o_done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_UPDATE,
    S_DONE
  } state_t;

  localparam int                STEP_W    = $clog2(SWEEPS_PER_STEP + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_SPINS - 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SWEEPS_PER_STEP - 1);

  state_t              r_state;
  logic [IDX_W-1:0]    r_idx;
  logic [15:0]         r_sweep_cnt;
  logic [15:0]         r_num_sweeps;
  logic [STEP_W-1:0]   r_step_cnt;
  logic signed [3:0]   r_field;
  logic [4:0]          r_lfsr;
  logic [N_SPINS-1:0]  r_spins;
  logic [1:0]          r_bit_shift;
  logic                r_field_req;
  logic                r_busy;
  logic                r_done;

  logic                w_transfer;
  logic signed [3:0]   w_rng;
  logic signed [3:0]   w_shifted;
  logic                w_spin_new;
  logic [4:0]          w_lfsr_next;
  logic [1:0]          w_next_shift;
  logic [15:0]         w_sweep_inc;
  logic                w_idx_last;
  logic                w_step_last;
  logic                w_sweep_last;

  assign w_transfer   = r_field_req & i_field_valid;
  assign w_rng        = r_lfsr[3:0];
  assign w_lfsr_next  = {r_lfsr[3:0], r_lfsr[4] ^ r_lfsr[2]};
  assign w_sweep_inc  = r_sweep_cnt + 16'd1;
  assign w_idx_last   = (r_idx == LAST_IDX);
  assign w_step_last  = (r_step_cnt == LAST_STEP);
  assign w_sweep_last = (w_sweep_inc == r_num_sweeps);
  // Both operands are signed, so this is a two's-complement comparison.
  assign w_spin_new   = (w_shifted < w_rng);

  // Shifts stay 4 bits wide on purpose: large fields wrap rather than saturate.
  always_comb begin
    // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
    w_shifted = r_field;
    case (r_bit_shift)
      2'b01:   w_shifted = r_field >>> 1;
      2'b10:   w_shifted = r_field <<< 1;
      2'b11:   w_shifted = r_field <<< 2;
      default: w_shifted = r_field;
    endcase
  end

  // Beta schedule: 01 -> 00 -> 10 -> 11, then hold.
  always_comb begin
    w_next_shift = 2'b11;
    case (r_bit_shift)
      2'b01:   w_next_shift = 2'b00;
      2'b00:   w_next_shift = 2'b10;
      default: w_next_shift = 2'b11;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_sweep_cnt  <= '0;
      r_num_sweeps <= '0;
      r_step_cnt   <= '0;
      r_field      <= '0;
      r_lfsr       <= 5'b00001;
      r_spins      <= '0;
      r_bit_shift  <= 2'b01;
      r_field_req  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_num_sweeps <= i_num_sweeps;
            r_idx        <= '0;
            r_sweep_cnt  <= '0;
            r_step_cnt   <= '0;
            r_bit_shift  <= 2'b01;
            if (i_num_sweeps == 16'd0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state     <= S_FETCH;
              r_field_req <= 1'b1;
              r_busy      <= 1'b1;
            end
          end
        end

        S_FETCH: begin
          if (i_abort) begin
            r_state     <= S_IDLE;
            r_field_req <= 1'b0;
            r_busy      <= 1'b0;
          end else if (w_transfer) begin
            r_field     <= i_field_val;
            r_field_req <= 1'b0;
            r_state     <= S_UPDATE;
          end
        end

        S_UPDATE: begin
          if (i_abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_spins[r_idx] <= w_spin_new;
            r_lfsr         <= w_lfsr_next;
            if (!w_idx_last) begin
              r_idx       <= r_idx + IDX_W'(1);
              r_state     <= S_FETCH;
              r_field_req <= 1'b1;
            end else begin
              r_idx       <= '0;
              r_sweep_cnt <= w_sweep_inc;
              if (w_step_last) begin
                r_step_cnt  <= '0;
                r_bit_shift <= w_next_shift;
              end else begin
                r_step_cnt <= r_step_cnt + STEP_W'(1);
              end
              if (w_sweep_last) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
              end else begin
                r_state     <= S_FETCH;
                r_field_req <= 1'b1;
              end
            end
          end
        end

        S_DONE: r_state <= S_IDLE;

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_field_req = r_field_req;
  assign o_field_idx = r_idx;
  assign o_spins     = r_spins;
  assign o_bit_shift = r_bit_shift;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_pbit_gibbs_scheduler.sv
// Directed-plus-random bench for pbit_gibbs_scheduler; expected spins come from an
// arithmetic model of the sampling rule, LFSR sequence and beta schedule.
module tb_pbit_gibbs_scheduler;

  localparam int N   = 4;
  localparam int IW  = 2;
  localparam int SPS = 2;

  logic          clk;
  logic          reset;
  logic          i_start;
  logic          i_abort;
  logic [15:0]   i_num_sweeps;
  logic          o_field_req;
  logic [IW-1:0] o_field_idx;
  logic          i_field_valid;
  logic [3:0]    i_field_val;
  logic [N-1:0]  o_spins;
  logic [1:0]    o_bit_shift;
  logic          o_busy;
  logic          o_done;

  pbit_gibbs_scheduler #(
    .N_SPINS(N), .IDX_W(IW), .SWEEPS_PER_STEP(SPS)
  ) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_abort(i_abort),
    .i_num_sweeps(i_num_sweeps), .o_field_req(o_field_req), .o_field_idx(o_field_idx),
    .i_field_valid(i_field_valid), .i_field_val(i_field_val), .o_spins(o_spins),
    .o_bit_shift(o_bit_shift), .o_busy(o_busy), .o_done(o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int           m_lfsr;
  logic [N-1:0] m_spins;
  int           sched [4] = '{1, 0, 2, 3};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int wrap4(input int x);
    int m;
    m = ((x % 16) + 16) % 16;
    return (m >= 8) ? m - 16 : m;
  endfunction

  function automatic int code_for(input int sweep);
    int step;
    step = sweep / SPS;
    return sched[(step > 3) ? 3 : step];
  endfunction

  task automatic model_reset();
    m_lfsr  = 1;
    m_spins = '0;
  endtask

  task automatic model_update(input int i, input int code, input int f);
    int sh;
    int rng;
    case (code)
      0:       sh = f;
      1:       sh = f >>> 1;
      2:       sh = wrap4(f * 2);
      default: sh = wrap4(f * 4);
    endcase
    rng        = wrap4(m_lfsr % 16);
    m_spins[i] = (sh < rng);
    m_lfsr     = ((m_lfsr * 2) % 32) + (((m_lfsr >> 4) & 1) ^ ((m_lfsr >> 2) & 1));
  endtask

  // One spin: optional stall cycles in FETCH, transfer, then UPDATE.
  task automatic do_spin(input int i, input int s, input int stalls, input int fval);
    int f;
    for (int c = 0; c < stalls; c++) begin
      check("stall_req", o_field_req, 1);
      check("stall_idx", o_field_idx, i);
      check("stall_spins", o_spins, m_spins);
      i_field_val = 4'($urandom);
      i_start     = 1'($urandom_range(0, 1));
      tick();
    end
    i_start = 1'($urandom_range(0, 1));
    check("fetch_req", o_field_req, 1);
    check("fetch_idx", o_field_idx, i);
    check("fetch_busy", o_busy, 1);
    check("bit_shift", o_bit_shift, code_for(s));
    f = (fval > 7) ? int'($urandom_range(0, 15)) - 8 : fval;
    i_field_val   = 4'(f);
    i_field_valid = 1'b1;
    tick();
    i_field_valid = 1'b0;
    i_start       = 1'b0;
    check("update_req", o_field_req, 0);
    check("update_busy", o_busy, 1);
    model_update(i, code_for(s), f);
    tick();
    check("spins", o_spins, m_spins);
  endtask

  task automatic start_run(input int num);
    i_num_sweeps = 16'(num);
    i_start      = 1'b1;
    tick();
    i_start      = 1'b0;
    i_num_sweeps = 16'($urandom);
  endtask

  // Full run; stall_at selects one spin (global count) that stalls exactly 5 cycles.
  task automatic run(input int num, input int stall_max, input int stall_at, input int fval);
    int k;
    start_run(num);
    if (num == 0) begin
      check("zero_done", o_done, 1);
      check("zero_req", o_field_req, 0);
      check("zero_busy", o_busy, 0);
      check("zero_spins", o_spins, m_spins);
      tick();
      check("zero_done_clr", o_done, 0);
      return;
    end
    k = 0;
    for (int s = 0; s < num; s++) begin
      for (int i = 0; i < N; i++) begin
        do_spin(i, s, (k == stall_at) ? 5 : int'($urandom_range(0, stall_max)), fval);
        k++;
      end
    end
    check("done", o_done, 1);
    check("done_busy", o_busy, 0);
    check("done_req", o_field_req, 0);
    tick();
    check("done_clr", o_done, 0);
    check("final_shift", o_bit_shift, code_for(num));
  endtask

  task automatic abort_run(input int spins_before, input bit in_update);
    start_run(2);
    for (int i = 0; i < spins_before; i++) do_spin(i, 0, 0, 99);
    check("abort_pre_req", o_field_req, 1);
    i_field_val   = 4'($urandom);
    i_field_valid = 1'b1;
    if (in_update) begin
      tick();
      i_field_valid = 1'b0;
      check("abort_in_update", o_field_req, 0);
    end
    i_abort = 1'b1;
    tick();
    i_abort       = 1'b0;
    i_field_valid = 1'b0;
    check("abort_busy", o_busy, 0);
    check("abort_req", o_field_req, 0);
    check("abort_done", o_done, 0);
    check("abort_spins", o_spins, m_spins);
    check("abort_shift", o_bit_shift, code_for(0));
    tick();
    check("abort_done_later", o_done, 0);
    check("abort_idle_busy", o_busy, 0);
  endtask

  initial begin
    reset         = 1'b1;
    i_start       = 1'b0;
    i_abort       = 1'b0;
    i_num_sweeps  = '0;
    i_field_valid = 1'b0;
    i_field_val   = '0;
    model_reset();
    repeat (3) tick();
    check("rst_spins", o_spins, 0);
    check("rst_shift", o_bit_shift, 2'b01);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_req", o_field_req, 0);
    check("rst_idx", o_field_idx, 0);
    reset = 1'b0;
    tick();

    // Zero field, one sweep: rng 1,2,4,-7 gives 0111 after 8 edges.
    run(1, 0, -1, 0);
    check("t1_spins_const", o_spins, 4'b0111);

    run(0, 0, -1, 99);

    // Exactly five stall cycles on the fourth spin.
    run(2, 0, 3, 99);

    // Random fields and stalls across the whole beta schedule.
    run(9, 2, -1, 99);

    // Most negative field exercises arithmetic shift and the wrap of both left shifts.
    run(8, 0, -1, -8);

    // Abort together with a transfer, then abort during UPDATE.
    abort_run(1, 1'b0);
    abort_run(2, 1'b1);
    run(3, 1, -1, 99);

    // Asynchronous reset while in UPDATE.
    start_run(1);
    i_field_val   = 4'd5;
    i_field_valid = 1'b1;
    tick();
    i_field_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("midrst_spins", o_spins, 0);
    check("midrst_shift", o_bit_shift, 2'b01);
    check("midrst_busy", o_busy, 0);
    check("midrst_req", o_field_req, 0);
    check("midrst_done", o_done, 0);
    check("midrst_idx", o_field_idx, 0);
    tick();
    reset = 1'b0;
    tick();
    run(1, 0, -1, 0);
    check("midrst_lfsr_seq", o_spins, 4'b0111);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
